// File: rtl/regfile_wb_scheduler_if.sv
// Handshake and write-port bundle for the register-file writeback scheduler.
// Ports: issue, ALU/load writeback, register-file write, hazard check, status.
interface regfile_wb_scheduler_if #(
    parameter int DW   = 16,
    parameter int AW   = 3,
    parameter int NREG = 8
);
    logic            iss_valid;
    logic [AW-1:0]   iss_dr;
    logic            iss_ready;

    logic            alu_valid;
    logic [AW-1:0]   alu_dr;
    logic [DW-1:0]   alu_data;
    logic            alu_ready;

    logic            mem_valid;
    logic [AW-1:0]   mem_dr;
    logic [DW-1:0]   mem_data;
    logic            mem_ready;

    logic            rf_we;
    logic [AW-1:0]   rf_dr;
    logic [DW-1:0]   rf_data;

    logic [AW-1:0]   chk_sr1;
    logic [AW-1:0]   chk_sr2;
    logic            chk_stall;
    logic [NREG-1:0] busy;
    logic            err_underflow;

    // Scheduler side
    modport slave (
        input  iss_valid, iss_dr,
        input  alu_valid, alu_dr, alu_data,
        input  mem_valid, mem_dr, mem_data,
        input  chk_sr1, chk_sr2,
        output iss_ready, alu_ready, mem_ready,
        output rf_we, rf_dr, rf_data,
        output chk_stall, busy, err_underflow
    );

    // Pipeline / environment side
    modport master (
        output iss_valid, iss_dr,
        output alu_valid, alu_dr, alu_data,
        output mem_valid, mem_dr, mem_data,
        output chk_sr1, chk_sr2,
        input  iss_ready, alu_ready, mem_ready,
        input  rf_we, rf_dr, rf_data,
        input  chk_stall, busy, err_underflow
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the single register-file write port between load and ALU
// writebacks and tracks per-register pending writes for decode hazards.
// Ports: clk, rst (sync, active-high), wb_if (slave modport of
// regfile_wb_scheduler_if: issue, ALU/load requests, rf write, status).
module regfile_wb_scheduler #(
    parameter int DW       = 16,
    parameter int AW       = 3,
    parameter int NREG     = 8,
    parameter int CNT_W    = 2,
    parameter int MAX_PEND = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_wb_scheduler_if.slave  wb_if
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PEND);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic             err_q, err_d;
    logic             rf_we_q, rf_we_d;
    logic [AW-1:0]    rf_dr_q, rf_dr_d;
    logic [DW-1:0]    rf_data_q, rf_data_d;

    logic             iss_acc;
    logic             alu_acc;
    logic             mem_acc;
    logic [NREG-1:0]  inc_v;
    logic [NREG-1:0]  dec_v;
    logic [NREG-1:0]  busy;

    // Load is older in program order, so it always owns the write port.
    assign wb_if.mem_ready = ~rst;
    assign wb_if.alu_ready = ~rst & ~wb_if.mem_valid;
    assign wb_if.iss_ready = ~rst & (cnt_q[wb_if.iss_dr] < MAX_C);

    assign mem_acc = wb_if.mem_valid & wb_if.mem_ready;
    assign alu_acc = wb_if.alu_valid & wb_if.alu_ready;
    assign iss_acc = wb_if.iss_valid & wb_if.iss_ready;

    // Output staging register: accepted request becomes the next rf write.
    always_comb begin
        rf_we_d   = mem_acc | alu_acc;
        rf_dr_d   = rf_dr_q;
        rf_data_d = rf_data_q;
        if (mem_acc) begin
            rf_dr_d   = wb_if.mem_dr;
            rf_data_d = wb_if.mem_data;
        end else if (alu_acc) begin
            rf_dr_d   = wb_if.alu_dr;
            rf_data_d = wb_if.alu_data;
        end
    end

    // Pending-write scoreboard. An issue and a commit to the same register
    // cancel out; a commit against an empty counter is flagged, not wrapped.
    always_comb begin
        inc_v = '0;
        dec_v = '0;
        err_d = err_q;
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
            inc_v[i] = iss_acc & (wb_if.iss_dr == AW'(i));
            dec_v[i] = rf_we_q & (rf_dr_q == AW'(i));
            if (dec_v[i] && (cnt_q[i] == '0)) begin
                err_d = 1'b1;
            end
            if (inc_v[i] && !dec_v[i]) begin
                cnt_d[i] = cnt_q[i] + ONE_C;
            end else if (dec_v[i] && !inc_v[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - ONE_C;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
            err_q     <= 1'b0;
            rf_we_q   <= 1'b0;
            rf_dr_q   <= '0;
            rf_data_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            err_q     <= err_d;
            rf_we_q   <= rf_we_d;
            rf_dr_q   <= rf_dr_d;
            rf_data_q <= rf_data_d;
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_busy
        assign busy[g] = (cnt_q[g] != '0);
    end

    assign wb_if.busy          = busy;
    assign wb_if.chk_stall     = busy[wb_if.chk_sr1] | busy[wb_if.chk_sr2];
    assign wb_if.err_underflow = err_q;
    assign wb_if.rf_we         = rf_we_q;
    assign wb_if.rf_dr         = rf_dr_q;
    assign wb_if.rf_data       = rf_data_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios then random traffic,
// every cycle compared against a pending-count reference model.
module tb_regfile_wb_scheduler;

    logic clk = 1'b0;
    logic rst;

    int nasserts = 0;
    int nfail    = 0;

    int          mcnt [8];
    bit          merr;
    bit          mwe;
    logic [2:0]  mdr;
    logic [15:0] mdata;

    regfile_wb_scheduler_if #(.DW(16), .AW(3), .NREG(8)) bus ();

    regfile_wb_scheduler #(
        .DW(16), .AW(3), .NREG(8), .CNT_W(2), .MAX_PEND(3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wb_if (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nasserts++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mcnt[i] = 0;
        merr  = 0;
        mwe   = 0;
        mdr   = '0;
        mdata = '0;
    endtask

    // Reference: counts are plain integers of outstanding writes per register.
    task automatic model_edge();
        bit iss_ok;
        if (rst) begin
            model_clear();
        end else begin
            iss_ok = bus.iss_valid && (mcnt[bus.iss_dr] < 3);
            if (mwe && mcnt[mdr] == 0) merr = 1;
            if (!(iss_ok && mwe && bus.iss_dr == mdr)) begin
                if (iss_ok) mcnt[bus.iss_dr] += 1;
                if (mwe && mcnt[mdr] > 0) mcnt[mdr] -= 1;
            end
            if (bus.mem_valid) begin
                mwe = 1; mdr = bus.mem_dr; mdata = bus.mem_data;
            end else if (bus.alu_valid) begin
                mwe = 1; mdr = bus.alu_dr; mdata = bus.alu_data;
            end else begin
                mwe = 0;
            end
        end
    endtask

    task automatic check_all();
        logic [7:0] eb;
        for (int i = 0; i < 8; i++) eb[i] = (mcnt[i] != 0);
        chk("iss_ready", bus.iss_ready, !rst && mcnt[bus.iss_dr] < 3);
        chk("mem_ready", bus.mem_ready, !rst);
        chk("alu_ready", bus.alu_ready, !rst && !bus.mem_valid);
        chk("rf_we", bus.rf_we, mwe);
        chk("rf_dr", bus.rf_dr, mdr);
        chk("rf_data", bus.rf_data, mdata);
        chk("busy", bus.busy, eb);
        chk("chk_stall", bus.chk_stall, eb[bus.chk_sr1] | eb[bus.chk_sr2]);
        chk("err_underflow", bus.err_underflow, merr);
    endtask

    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        bus.iss_valid = 0;
        bus.alu_valid = 0;
        bus.mem_valid = 0;
    endtask

    initial begin
        rst = 1;
        bus.iss_valid = 1; bus.iss_dr = 0;
        bus.alu_valid = 1; bus.alu_dr = 1; bus.alu_data = 16'h1111;
        bus.mem_valid = 1; bus.mem_dr = 2; bus.mem_data = 16'h2222;
        bus.chk_sr1 = 0; bus.chk_sr2 = 0;
        model_clear();
        @(posedge clk);
        #1;

        // Reset held with all valids high
        repeat (3) step();
        #1;
        chk("rst_iss_ready", bus.iss_ready, 0);
        chk("rst_alu_ready", bus.alu_ready, 0);
        chk("rst_mem_ready", bus.mem_ready, 0);
        chk("rst_rf_we", bus.rf_we, 0);
        chk("rst_busy", bus.busy, 8'h00);
        chk("rst_err", bus.err_underflow, 0);

        // Single ALU write to r3
        rst = 0;
        idle();
        bus.iss_valid = 1; bus.iss_dr = 3;
        step();
        idle();
        bus.chk_sr1 = 3;
        #1;
        chk("iss3_busy", bus.busy, 8'h08);
        chk("iss3_stall", bus.chk_stall, 1);
        bus.alu_valid = 1; bus.alu_dr = 3; bus.alu_data = 16'h1234;
        step();
        idle();
        #1;
        chk("alu3_we", bus.rf_we, 1);
        chk("alu3_dr", bus.rf_dr, 3);
        chk("alu3_data", bus.rf_data, 16'h1234);
        chk("alu3_busy_n1", bus.busy, 8'h08);
        step();
        chk("alu3_busy_n2", bus.busy, 8'h00);
        chk("alu3_stall_n2", bus.chk_stall, 0);

        // Collision: load wins, ALU held one cycle
        bus.iss_valid = 1; bus.iss_dr = 1;
        step();
        bus.iss_dr = 2;
        step();
        idle();
        bus.alu_valid = 1; bus.alu_dr = 1; bus.alu_data = 16'hAAAA;
        bus.mem_valid = 1; bus.mem_dr = 2; bus.mem_data = 16'h5555;
        #1;
        chk("col_alu_ready", bus.alu_ready, 0);
        step();
        bus.mem_valid = 0;
        #1;
        chk("col_alu_ready2", bus.alu_ready, 1);
        chk("col_we1", bus.rf_we, 1);
        chk("col_data1", bus.rf_data, 16'h5555);
        step();
        bus.alu_valid = 0;
        #1;
        chk("col_we2", bus.rf_we, 1);
        chk("col_data2", bus.rf_data, 16'hAAAA);
        step();
        step();
        chk("col_busy", bus.busy, 8'h00);

        // Saturation on r5
        bus.iss_valid = 1; bus.iss_dr = 5;
        repeat (3) step();
        #1;
        chk("sat_r5_ready", bus.iss_ready, 0);
        bus.iss_dr = 4;
        #1;
        chk("sat_r4_ready", bus.iss_ready, 1);
        step();
        idle();
        bus.alu_valid = 1; bus.alu_dr = 5; bus.alu_data = 16'h0505;
        step();
        idle();
        bus.iss_dr = 5;
        #1;
        chk("sat_r5_still", bus.iss_ready, 0);
        step();
        chk("sat_r5_back", bus.iss_ready, 1);

        // Issue and commit on r6 at the same edge
        bus.iss_valid = 1; bus.iss_dr = 6;
        step();
        idle();
        bus.alu_valid = 1; bus.alu_dr = 6; bus.alu_data = 16'h0606;
        step();
        idle();
        bus.iss_valid = 1; bus.iss_dr = 6;
        step();
        idle();
        chk("sim_busy6", bus.busy[6], 1);
        bus.alu_valid = 1; bus.alu_dr = 6; bus.alu_data = 16'h0607;
        step();
        idle();
        step();
        chk("sim_busy6_clr", bus.busy[6], 0);

        // Underflow on r0, then reset with a staged write
        bus.mem_valid = 1; bus.mem_dr = 0; bus.mem_data = 16'hDEAD;
        step();
        idle();
        step();
        chk("uf_err", bus.err_underflow, 1);
        step();
        chk("uf_err_sticky", bus.err_underflow, 1);
        bus.mem_valid = 1; bus.mem_dr = 7; bus.mem_data = 16'hBEEF;
        step();
        idle();
        rst = 1;
        step();
        rst = 0;
        #1;
        chk("mrst_we", bus.rf_we, 0);
        chk("mrst_err", bus.err_underflow, 0);
        chk("mrst_busy", bus.busy, 8'h00);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            rst           = ($urandom_range(0, 49) == 0);
            bus.iss_valid = $urandom_range(0, 1);
            bus.iss_dr    = 3'($urandom_range(0, 7));
            bus.alu_valid = $urandom_range(0, 1);
            bus.alu_dr    = 3'($urandom_range(0, 7));
            bus.alu_data  = 16'($urandom);
            bus.mem_valid = ($urandom_range(0, 2) == 0);
            bus.mem_dr    = 3'($urandom_range(0, 7));
            bus.mem_data  = 16'($urandom);
            bus.chk_sr1   = 3'($urandom_range(0, 7));
            bus.chk_sr2   = 3'($urandom_range(0, 7));
            step();
        end
        rst = 0;
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nasserts, nfail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Schedules the single write port of the 8x16 register file between two writeback sources: the ALU result (younger) and the memory load result (older).
- Keeps a per-register pending-write scoreboard. Decode uses it to stall instructions whose source registers still have writes in flight.
- Sits between the execute/memory stages and the register file. It drives the register file's write-enable, destination and data inputs.

Parameters:
- DW, 16, data width
- AW, 3, register index width
- NREG, 8, number of registers (2^AW)
- CNT_W, 2, width of each pending-write counter
- MAX_PEND, 3, maximum outstanding writes per register (must be ≤ 2^CNT_W−1)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- iss_valid  in  1  decode is issuing an instruction that will write iss_dr
- iss_dr  in  AW  destination of the issuing instruction
- iss_ready  out  1  issue accepted this cycle
- alu_valid  in  1  ALU writeback request
- alu_dr  in  AW  ALU destination
- alu_data  in  DW  ALU result
- alu_ready  out  1  ALU request accepted
- mem_valid  in  1  load writeback request
- mem_dr  in  AW  load destination
- mem_data  in  DW  load data
- mem_ready  out  1  load request accepted
- rf_we  out  1  register-file write enable
- rf_dr  out  AW  register-file write destination
- rf_data  out  DW  register-file write data
- chk_sr1  in  AW  decode source 1 to check
- chk_sr2  in  AW  decode source 2 to check
- chk_stall  out  1  source hazard
- busy  out  NREG  bit i = register i has ≥1 pending write
- err_underflow  out  1  sticky: commit to register with zero pending count

Behaviour:
- Reset:
  - Only clk and rst are fixed by prior decision. Everything below is this block's spec.
  - While rst=1 at an edge: rf_we=0, rf_dr=0, rf_data=0, all counters=0, busy=0, err_underflow=0.
  - All ready outputs are 0 while rst is high (combinational gating).
  - A write staged but not yet committed when rst rises is dropped.
- Arbitration (combinational):
  - mem_ready = ~rst.
  - alu_ready = ~rst & ~mem_valid. The load is older in program order and always wins.
- Accept and commit:
  - Exactly one source is accepted per cycle (valid & ready).
  - Accept in cycle N loads the output register at edge N. rf_we=1 with that source's dr/data during cycle N+1; the register file writes at the end of N+1.
  - If neither source is accepted, rf_we=0 next cycle. rf_dr/rf_data hold their last values.
  - Write throughput is 1/cycle. There is no further buffering, and a request not accepted must be held by its source.
- Scoreboard:
  - Counters cnt[0..NREG-1].
  - iss_ready = ~rst & (cnt[iss_dr] < MAX_PEND). An issue is accepted on iss_valid & iss_ready.
  - A commit occurs on any cycle with rf_we=1, decrementing cnt[rf_dr] at that edge.
  - Same edge, same register, issue plus commit: count unchanged.
  - Same edge, different registers: both applied.
  - Commit when cnt[rf_dr]==0: count stays 0 and err_underflow is set until reset.
  - busy[i] = (cnt[i]!=0), combinational from the counters.
  - chk_stall = busy[chk_sr1] | busy[chk_sr2], combinational.
  - A register is non-busy from the cycle after its commit edge, so a reader sees the committed value.
- No bypass or forwarding in this block.

Test Plan:
- Reset: hold rst 3 cycles with alu_valid=mem_valid=iss_valid=1 → all ready=0, rf_we=0, busy=8'h00, err_underflow=0.
- Single ALU write:
  - Issue dr=3 → busy=8'h08, chk_sr1=3 gives chk_stall=1.
  - alu_valid dr=3 data=16'h1234 at cycle N → rf_we=1, rf_dr=3, rf_data=16'h1234 in N+1; busy=8'h00 from N+2.
- Collision: issue r1 and r2; same cycle alu(dr=1, 16'hAAAA) and mem(dr=2, 16'h5555) → mem accepted first (rf_data=16'h5555), alu_ready=0; ALU held and accepted next cycle (rf_data=16'hAAAA); two consecutive rf_we cycles.
- Saturation: issue r5 three times → iss_ready=0 for dr=5 while iss_dr=4 still accepted. Commit one r5 → iss_ready returns 1 the following cycle.
- Simultaneous issue and commit on r6 with cnt=1 → cnt stays 1, busy[6] stays 1. One more commit → busy[6]=0.
- Underflow and mid-operation reset:
  - mem write to r0 with cnt[0]=0 → err_underflow=1 and stays set.
  - Assert rst while a write is staged → rf_we=0 next cycle, err_underflow=0, busy=0.
